// File: rtl/sum_bcd_display_pkg.sv
// rtl/sum_bcd_display_pkg.sv - shared states, segment codes and limits for sum_bcd_display
package sum_bcd_display_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Widest binary input the two-nibble BCD scratch can hold (63 -> tens 6)
  localparam int WIDTH_MAX = 6;

  // Active-low 7-segment codes, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit to segment code; anything above 9 renders dark
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - 4-bit digit to active-low 7-segment code, >9 blank
module seg7_decoder
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Pure table lookup
  assign o_seg = seg_code(i_digit);

endmodule

// File: rtl/sum_bcd_display.sv
// rtl/sum_bcd_display.sv - serial double-dabble binary-to-BCD converter with 7-segment outputs
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_tens,
  output logic [3:0]       out_ones,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // Reject widths the two-digit scratch cannot represent
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("sum_bcd_display: WIDTH out of range");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_out_tens;
  logic [3:0]       r_out_ones;
  logic             r_out_valid;

  logic [3:0]       w_adj_tens;
  logic [3:0]       w_adj_ones;
  logic [WIDTH+7:0] w_shift;
  logic [3:0]       w_tens_digit;

  // One double-dabble step: add 3 to nibbles >=5, then shift the whole chain left
  assign w_adj_tens = (r_tens >= 4'd5) ? r_tens + 4'd3 : r_tens;
  assign w_adj_ones = (r_ones >= 4'd5) ? r_ones + 4'd3 : r_ones;
  assign w_shift    = {w_adj_tens, w_adj_ones, r_bin} << 1;

  // Capture, shift WIDTH times, publish on the last shift, hold until consumed
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= ST_IDLE;
      r_bin       <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
      r_cnt       <= '0;
      r_out_tens  <= '0;
      r_out_ones  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_bin   <= in_sum;
            r_tens  <= '0;
            r_ones  <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_tens <= w_shift[WIDTH+7:WIDTH+4];
          r_ones <= w_shift[WIDTH+3:WIDTH];
          r_bin  <= w_shift[WIDTH-1:0];
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_out_tens  <= w_shift[WIDTH+7:WIDTH+4];
            r_out_ones  <= w_shift[WIDTH+3:WIDTH];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_tens  = r_out_tens;
  assign out_ones  = r_out_ones;

  // Leading zero on the tens display is blanked by feeding an out-of-range digit
  assign w_tens_digit = (r_out_tens == 4'd0) ? 4'hF : r_out_tens;

  seg7_decoder u_seg_tens (
    .i_digit (w_tens_digit),
    .o_seg   (HEX1)
  );

  seg7_decoder u_seg_ones (
    .i_digit (r_out_ones),
    .o_seg   (HEX0)
  );

endmodule
